// File: rtl/dff_deser_pkg.sv
// Shared types and constants for the dff_deser serial-to-parallel receiver.
package dff_deser_pkg;

    localparam int unsigned DataWDefault = 8;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StStop
    } deser_state_e;

endpackage

// File: rtl/deser_out_reg.sv
// Output holding register with valid/ready handshake and overrun detection.
module deser_out_reg
    import dff_deser_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_vld_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              data_rdy_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_vld_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              overrun_q, overrun_d;
    logic              accept;

    assign accept = vld_q & data_rdy_i;

    always_comb begin
        data_d    = data_q;
        vld_d     = vld_q;
        overrun_d = 1'b0;
        if (word_vld_i) begin
            // A word slot frees up on the same edge as a handshake.
            if (!vld_q || accept) begin
                data_d = word_i;
                vld_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            vld_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            vld_q     <= vld_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o     = data_q;
    assign data_vld_o = vld_q;
    assign overrun_o  = overrun_q;

endmodule

// File: rtl/dff_deser.sv
// Serial receiver: start bit, DATA_W data bits LSB first, one stop bit.
module dff_deser
    import dff_deser_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    input  logic              data_rdy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CntW = $clog2(DATA_W);

    deser_state_e      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              good_stop;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        good_stop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bit_in) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                shift_d[cnt_q] = bit_in;
                cnt_d          = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // A low stop bit is a framing error, never a new start bit.
                state_d = StIdle;
                if (bit_in) begin
                    good_stop = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    deser_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .word_vld_i(good_stop),
        .word_i    (shift_q),
        .data_rdy_i(data_rdy),
        .data_o    (data_out),
        .data_vld_o(data_vld),
        .overrun_o (overrun)
    );

endmodule

// File: tb/tb_dff_deser.sv
// Self-checking bench for dff_deser: directed scenarios plus random frames vs a frame-level model.
`timescale 1ns/1ps
module tb_dff_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic [7:0] data_out;
    logic       data_vld;
    logic       data_rdy;
    logic       frame_err;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of what the consumer should observe after each edge.
    logic [7:0] exp_data;
    logic       exp_vld;
    logic       exp_ferr;
    logic       exp_ovr;

    always #5 clk = ~clk;

    dff_deser #(
        .DATA_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .data_out (data_out),
        .data_vld (data_vld),
        .data_rdy (data_rdy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    task automatic check(input string tag);
        n_tests++;
        assert (data_vld === exp_vld) else begin
            n_fail++;
            $error("FAIL %s data_vld: got %b want %b", tag, data_vld, exp_vld);
        end
        n_tests++;
        assert (data_out === exp_data) else begin
            n_fail++;
            $error("FAIL %s data_out: got %h want %h", tag, data_out, exp_data);
        end
        n_tests++;
        assert (frame_err === exp_ferr) else begin
            n_fail++;
            $error("FAIL %s frame_err: got %b want %b", tag, frame_err, exp_ferr);
        end
        n_tests++;
        assert (overrun === exp_ovr) else begin
            n_fail++;
            $error("FAIL %s overrun: got %b want %b", tag, overrun, exp_ovr);
        end
    endtask

    // ev: 0 = nothing completes this cycle, 1 = good stop of word w, 2 = bad stop.
    task automatic step(input logic b, input logic r, input logic rs, input int ev,
                        input logic [7:0] w, input string tag);
        logic acc;
        bit_in   = b;
        data_rdy = r;
        rst      = rs;
        @(posedge clk);
        if (rs) begin
            exp_data = 8'h00;
            exp_vld  = 1'b0;
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
        end else begin
            acc      = exp_vld && r;
            exp_ferr = (ev == 2);
            exp_ovr  = 1'b0;
            if (ev == 1) begin
                if (!exp_vld || acc) begin
                    exp_data = w;
                    exp_vld  = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (acc) begin
                exp_vld = 1'b0;
            end
        end
        #1;
        check(tag);
    endtask

    function automatic logic pick_rdy(input int mode);
        return (mode == 2) ? logic'($urandom_range(0, 1)) : (mode == 1);
    endfunction

    // rdy modes: 0 = low, 1 = high, 2 = random per cycle.
    task automatic send_frame(input logic [7:0] w, input logic good, input int rdy_body,
                              input int rdy_stop, input string tag);
        step(1'b0, pick_rdy(rdy_body), 1'b0, 0, 8'h00, tag);
        for (int i = 0; i < 8; i++) begin
            step(w[i], pick_rdy(rdy_body), 1'b0, 0, 8'h00, tag);
        end
        step(good, pick_rdy(rdy_stop), 1'b0, good ? 1 : 2, w, tag);
    endtask

    task automatic idle(input int n, input int rdy_mode, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1, pick_rdy(rdy_mode), 1'b0, 0, 8'h00, tag);
        end
    endtask

    initial begin
        rst      = 1'b1;
        bit_in   = 1'b1;
        data_rdy = 1'b0;
        exp_data = 8'h00;
        exp_vld  = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;

        step(1'b1, 1'b0, 1'b1, 0, 8'h00, "reset");
        step(1'b1, 1'b0, 1'b1, 0, 8'h00, "reset");

        idle(50, 2, "idle50");

        send_frame(8'hA5, 1'b1, 1, 1, "single_a5");
        idle(3, 1, "single_a5_after");

        send_frame(8'h3C, 1'b0, 1, 1, "bad_stop_3c");
        send_frame(8'h81, 1'b1, 1, 1, "good_81");
        idle(2, 1, "good_81_after");

        send_frame(8'h11, 1'b1, 0, 0, "ovr_11");
        send_frame(8'h22, 1'b1, 0, 0, "ovr_22");
        idle(3, 0, "ovr_hold");
        idle(2, 1, "ovr_accept");

        send_frame(8'h33, 1'b1, 0, 0, "sim_33");
        send_frame(8'h55, 1'b1, 0, 1, "sim_55");
        idle(3, 1, "sim_after");

        // Abort after start + 4 data bits; the partial word must never appear.
        step(1'b0, 1'b1, 1'b0, 0, 8'h00, "abort");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 8'h00, "abort");
        end
        step(1'b0, 1'b1, 1'b1, 0, 8'h00, "abort_rst");
        send_frame(8'hF0, 1'b1, 1, 1, "post_rst_f0");
        idle(2, 1, "post_rst_after");

        for (int f = 0; f < 60; f++) begin
            send_frame(8'($urandom), ($urandom_range(0, 99) < 85), 2, 2, "random");
            idle($urandom_range(0, 2), 2, "random_gap");
        end
        idle(6, 1, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
